// File: rtl/fb_axi_pkg.sv
// Shared AXI read-channel constants, FSM state type and AR queue entry type
// for the VGA frame-buffer read responder.
package fb_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
   localparam logic [2:0] AXI_SIZE_8B     = 3'h3;
   localparam int         AR_ADDR_W       = 64;

   typedef enum logic {IDLE, BURST} fsm_state_t;

   typedef struct packed {
      logic [AR_ADDR_W-1:0] addr;
      logic [7:0]           len;
      logic                 err_slv;
   } ar_entry_t;

   // SLVERR dominates DECERR on any beat.
   function automatic logic [1:0] beat_resp(input logic slv, input logic dec);
      if (slv)
         return AXI_RESP_SLVERR;
      else if (dec)
         return AXI_RESP_DECERR;
      else
         return AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/fb_ar_fifo.sv
// Two-entry read-address queue; push and pop may occur in the same cycle,
// including when full.
module fb_ar_fifo
   import fb_axi_pkg::*;
(
   input  logic      clk_a,
   input  logic      reset_a,
   input  logic      push,
   input  logic      pop,
   input  ar_entry_t din,
   output ar_entry_t dout,
   output logic      full,
   output logic      empty
);

   ar_entry_t  slot [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = slot[rd_ptr_q];

   always_ff @(posedge clk_a) begin
      if (reset_a) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push)
            wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)
            rd_ptr_q <= ~rd_ptr_q;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_a) begin
      if (do_push)
         slot[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fb_axi_rd_responder.sv
// AXI4 read responder serving INCR bursts from an internal word RAM with a side load port.
// Optional build macro FB_RD_PATTERN_EN adds pattern_i for generated test-pattern data.
module fb_axi_rd_responder
   import fb_axi_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                         clk_a,
   input  logic                         reset_a,
   input  logic                         arvalid_i,
   output logic                         arready_o,
   input  logic [ADDR_WIDTH-1:0]        araddr_i,
   input  logic [1:0]                   arburst_i,
   input  logic [7:0]                   arlen_i,
   input  logic [2:0]                   arsize_i,
   output logic                         rvalid_o,
   input  logic                         rready_i,
   output logic [DATA_WIDTH-1:0]        rdata_o,
   output logic [1:0]                   rresp_o,
   output logic                         rlast_o,
`ifdef FB_RD_PATTERN_EN
   input  logic                         pattern_i,
`endif
   input  logic                         wr_en_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0]        wr_data_i
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   fsm_state_t            state_q, state_d;
   ar_entry_t             ar_in, ar_head;
   logic                  ar_en_q, fifo_full, fifo_empty, ar_push, ar_pop, load;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [ADDR_WIDTH-1:0] word_p0;
   logic [7:0]            cnt_p0;
   logic                  slv_p0, below_p0;
   logic                  out_free, issue, last_issue, beat_dec;
   logic [1:0]            resp_p0;
   logic [DATA_WIDTH-1:0] data_p0;
   logic                  vld_p1, rlast_p1;
   logic [1:0]            rresp_p1;
   logic [DATA_WIDTH-1:0] rdata_p1;

`ifdef FB_RD_PATTERN_EN
   function automatic logic [DATA_WIDTH-1:0] pattern_word(input logic [ADDR_WIDTH-1:0] w);
      logic [DATA_WIDTH-1:0] r;
      logic [ADDR_WIDTH-1:0] v;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         v = (w << 2) + ADDR_WIDTH'(k);
         r[16*k +: 16] = {4'h0, v[11:0]};
      end
      return r;
   endfunction
`endif

   always_ff @(posedge clk_a) begin
      if (wr_en_i)
         mem[wr_addr_i] <= wr_data_i;
   end

   // AR acceptance: ready opens the cycle after reset release.
   always_ff @(posedge clk_a) begin
      if (reset_a)
         ar_en_q <= 1'b0;
      else
         ar_en_q <= 1'b1;
   end

   assign arready_o     = ar_en_q && !fifo_full;
   assign ar_push       = arvalid_i && arready_o;
   assign ar_in.addr    = AR_ADDR_W'(araddr_i);
   assign ar_in.len     = arlen_i;
   assign ar_in.err_slv = (arsize_i != AXI_SIZE_8B) || (arburst_i != AXI_BURST_INCR) ||
                          (araddr_i[2:0] != 3'b000);

   fb_ar_fifo u_ar_fifo (
      .clk_a   (clk_a),
      .reset_a (reset_a),
      .push    (ar_push),
      .pop     (ar_pop),
      .din     (ar_in),
      .dout    (ar_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_free   = !vld_p1 || rready_i;
   assign issue      = (state_q == BURST) && out_free;
   assign last_issue = (cnt_p0 == 8'd0);

   always_ff @(posedge clk_a) begin
      if (reset_a)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ar_pop  = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               ar_pop  = 1'b1;
               load    = 1'b1;
               state_d = BURST;
            end
         end
         BURST: begin
            if (issue && last_issue) begin
               if (!fifo_empty) begin
                  ar_pop = 1'b1;
                  load   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // p0: burst issue pointer, loaded on pop and stepped per issued beat
   assign head_addr = ADDR_WIDTH'(ar_head.addr);

   always_ff @(posedge clk_a) begin
      if (load) begin
         word_p0  <= (head_addr - BASE_ADDR) >> 3;
         below_p0 <= (head_addr < BASE_ADDR);
         slv_p0   <= ar_head.err_slv;
         cnt_p0   <= ar_head.len;
      end else if (issue) begin
         word_p0  <= word_p0 + ADDR_WIDTH'(1);
         cnt_p0   <= cnt_p0 - 8'd1;
      end
   end

   assign beat_dec = below_p0 || (word_p0 >= ADDR_WIDTH'(MEM_DEPTH));
   assign resp_p0  = beat_resp(slv_p0, beat_dec);

   always_comb begin
      data_p0 = '0;
      if (resp_p0 == AXI_RESP_OKAY) begin
`ifdef FB_RD_PATTERN_EN
         if (pattern_i)
            data_p0 = pattern_word(word_p0);
         else
            data_p0 = mem[word_p0[IDX_W-1:0]];
`else
         data_p0 = mem[word_p0[IDX_W-1:0]];
`endif
      end
   end

   // p1: registered R channel, held while stalled
   always_ff @(posedge clk_a) begin
      if (reset_a) begin
         vld_p1   <= 1'b0;
         rlast_p1 <= 1'b0;
         rresp_p1 <= AXI_RESP_OKAY;
         rdata_p1 <= '0;
      end else if (out_free) begin
         vld_p1 <= issue;
         if (issue) begin
            rdata_p1 <= data_p0;
            rresp_p1 <= resp_p0;
            rlast_p1 <= last_issue;
         end
      end
   end

   assign rvalid_o = vld_p1;
   assign rdata_o  = rdata_p1;
   assign rresp_o  = rresp_p1;
   assign rlast_o  = rlast_p1;

endmodule
